n1_prog_loader: RTL and testbench

Byte-stream program loader for the n1 core: accepts a framed byte stream from the pins over a valid/ready handshake and assembles 16-bit instruction words. Writes those words into the core's program RAM from address 0 upward. Holds the core in reset until a complete, well-formed frame has been written. It is the writer side of the program RAM that the n1 core fetches from.

---
 rtl/n1_prog_loader.sv | 91 +++++++++
 tb/tb_n1_prog_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/n1_prog_loader.sv
// n1_prog_loader: framed byte-stream loader that writes 16-bit words into program RAM and releases the core; N1_LOADER_CSUM_EN adds a trailing checksum byte
module n1_prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] word_count
);
   localparam logic [2:0] IDLE = 3'd0, LEN = 3'd1, HI = 3'd2, LO = 3'd3, CSUM = 3'd4, DONE = 3'd5, ERR = 3'd6;
   localparam logic [7:0] HDR = 8'hA5;
`ifdef N1_LOADER_CSUM_EN
   localparam logic [2:0] FRAME_END = CSUM;
   logic [7:0] acc;
`else
   localparam logic [2:0] FRAME_END = DONE;
`endif
   logic [2:0] state, nxt;
   logic [7:0] len, hi;
   logic xfer, last, len_ok;
   assign xfer   = in_valid && in_ready;
   assign last   = ({1'b0, word_count} + 1'b1) == (ADDR_W + 1)'(len);
   assign len_ok = (in_data != 8'h00) && (32'(in_data) <= 32'(DEPTH));
   // next state on an accepted byte; idle cycles leave the state untouched
   always_comb begin
      nxt = state;
      if (xfer)
         case (state)
            IDLE, DONE, ERR: nxt = (in_data == HDR) ? LEN : state;
            LEN:             nxt = len_ok ? HI : ERR;
            HI:              nxt = LO;
            LO:              nxt = last ? FRAME_END : HI;
`ifdef N1_LOADER_CSUM_EN
            CSUM:            nxt = (8'(acc + in_data) == 8'h00) ? DONE : ERR;
`endif
            default:         nxt = IDLE;
         endcase
   end
   // state, status flags derived from the next state, word assembly and RAM write strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_run    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
         len        <= '0;
         hi         <= '0;
`ifdef N1_LOADER_CSUM_EN
         acc        <= '0;
`endif
      end else begin
         state    <= nxt;
         in_ready <= 1'b1;
         mem_we   <= xfer && state == LO;
         busy     <= nxt inside {LEN, HI, LO, CSUM};
         done     <= nxt == DONE;
         err      <= nxt == ERR;
         cpu_run  <= nxt == DONE;
         if (xfer && state == LEN && len_ok) begin
            len        <= in_data;
            word_count <= '0;
         end
         if (xfer && state == HI) hi <= in_data;
         if (xfer && state == LO) begin
            mem_addr   <= word_count;
            mem_wdata  <= {hi, in_data};
            word_count <= word_count + 1'b1;
         end
`ifdef N1_LOADER_CSUM_EN
         if (xfer && state == LEN) acc <= '0;
         if (xfer && (state == HI || state == LO)) acc <= acc + in_data;
`endif
      end
   end
endmodule

// File: tb/tb_n1_prog_loader.sv
// tb_n1_prog_loader: scoreboard bench for n1_prog_loader; follows N1_LOADER_CSUM_EN like the design
module tb_n1_prog_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 255;
   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      logic        run;
   } wr_t;
   logic clk = 0, rst, in_valid, in_ready, mem_we, cpu_run, busy, done, err;
   logic [7:0] in_data, mem_addr, word_count;
   logic [15:0] mem_wdata;
   int errs = 0, checks = 0;
   wr_t exp_q[$];
   logic [15:0] wq[$];
   logic d_exp = 0, e_exp = 0;
   logic [7:0] wc_exp = 0;

   n1_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
      .busy(busy), .done(done), .err(err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   // write monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data || cpu_run !== e.run) begin
               errs++;
               $display("FAIL write: got addr=%h data=%h run=%b, required addr=%h data=%h run=%b",
                        mem_addr, mem_wdata, cpu_run, e.addr, e.data, e.run);
            end
         end
      end
   end

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h, required %h", n, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) begin
         in_valid = 0;
         in_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid = 1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic status(input string n);
      chk({n, "_done"}, done, d_exp);
      chk({n, "_err"}, err, e_exp);
      chk({n, "_run"}, cpu_run, d_exp);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_wc"}, word_count, wc_exp);
   endtask

   task automatic reset_vals(input string n);
      chk({n, "_ready"}, in_ready, 0);
      chk({n, "_we"}, mem_we, 0);
      chk({n, "_addr"}, mem_addr, 0);
      chk({n, "_wdata"}, mem_wdata, 0);
      chk({n, "_run"}, cpu_run, 0);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_done"}, done, 0);
      chk({n, "_err"}, err, 0);
      chk({n, "_wc"}, word_count, 0);
   endtask

   task automatic junk(input logic [7:0] b);
      send(b == 8'hA5 ? 8'h5A : b);
      status("junk");
   endtask

   // frame model: n words from wq (random beyond), optional corrupted checksum
   task automatic frame(input int n, input bit bad);
      logic [7:0] s;
      logic [15:0] w;
      logic ok;
      send(8'hA5);
      chk("hdr_busy", busy, 1);
      chk("hdr_run", cpu_run, 0);
      chk("hdr_flags", {done, err}, 0);
      send(8'(n));
      if (n == 0 || n > DEPTH) begin
         d_exp = 0;
         e_exp = 1;
         status("badlen");
         return;
      end
      s = 0;
      for (int i = 0; i < n; i++) begin
         w = (i < wq.size()) ? wq[i] : 16'($urandom);
`ifdef N1_LOADER_CSUM_EN
         exp_q.push_back('{8'(i), w, 1'b0});
`else
         exp_q.push_back('{8'(i), w, i == n - 1});
`endif
         send(w[15:8]);
         send(w[7:0]);
         s = s + w[15:8] + w[7:0];
      end
      wc_exp = 8'(n);
`ifdef N1_LOADER_CSUM_EN
      chk("pre_csum_done", done, 0);
      chk("pre_csum_busy", busy, 1);
      send(bad ? 8'(-s) ^ 8'h01 : 8'(-s));
      ok = !bad;
`else
      ok = 1;
`endif
      d_exp = ok;
      e_exp = !ok;
      status("frame");
   endtask

   initial begin
      int n;
      rst = 1;
      in_valid = 0;
      in_data = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_vals("reset");
      rst = 0;
      n = 0;
      while (!in_ready && n < 5) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("ready_up", in_ready, 1);
      junk(8'h55);
      junk(8'h66);
      wq = '{16'h1234};
      frame(1, 0);
      wq = '{16'h0001, 16'h0002, 16'h0003};
      frame(3, 0);
      wq = '{16'h1234};
      frame(1, 1);
      wq = '{16'h0010};
      frame(1, 0);
      frame(0, 0);
      wq = '{};
      frame(255, 0);
      junk(8'h34);
      send(8'hA5);
      send(8'h02);
      send(8'hAB);
      rst = 1;
      #1;
      reset_vals("midrst");
      @(posedge clk);
      #1;
      rst = 0;
      d_exp = 0;
      e_exp = 0;
      wc_exp = 0;
      @(posedge clk);
      #1;
      chk("ready_again", in_ready, 1);
      wq = '{16'hCDEF};
      frame(1, 0);
      wq = '{};
      for (int k = 0; k < 20; k++) begin
         frame($urandom_range(0, 6), 1'($urandom));
         repeat ($urandom_range(0, 2)) junk(8'($urandom));
      end
      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
